tlb_pipe: RTL and testbench

Parametrised, registered-output TLB for the LoongArch32 core: fully associative TLBNUM entries, two search ports (fetch, load/store) with one-cycle registered results, a read/write port for TLBRD/TLBWR/TLBFILL, and a dedicated INVTLB port with illegal-op reporting. It adds reset-time invalidation, multi-hit detection and a free-running fill-index generator. It sits between the IF/EX address-translation stages and the CSR/TLB-instruction logic in WB.

---
 rtl/tlb_pkg.sv | 46 ++++
 rtl/tlb_lookup.sv | 81 ++++++++
 rtl/tlb_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_tlb_pipe.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB types and constants: page sizes, INVTLB op codes, entry and
// search-result layouts, and the virtual-page compare used by search and INVTLB.
package tlb_pkg;

   localparam logic [5:0] PS_4K = 6'd12;
   localparam logic [5:0] PS_4M = 6'd21;

   localparam logic [4:0] INV_ALL0     = 5'd0;
   localparam logic [4:0] INV_ALL1     = 5'd1;
   localparam logic [4:0] INV_G1       = 5'd2;
   localparam logic [4:0] INV_G0       = 5'd3;
   localparam logic [4:0] INV_ASID     = 5'd4;
   localparam logic [4:0] INV_ASID_VA  = 5'd5;
   localparam logic [4:0] INV_GASID_VA = 5'd6;

   typedef struct packed {
      logic [19:0] ppn;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        d;
      logic        v;
   } tlb_page_t;

   typedef struct packed {
      logic        e;
      logic        ps4m;
      logic [18:0] vppn;
      logic [9:0]  asid;
      logic        g;
      tlb_page_t   p0;
      tlb_page_t   p1;
   } tlb_entry_t;

   typedef struct packed {
      logic        found;
      logic        multi;
      logic [5:0]  ps;
      tlb_page_t   page;
   } tlb_result_t;

   // A 4MB entry spans 512 VPPNs, so its low 9 VPPN bits are ignored.
   function automatic logic va_eq(input tlb_entry_t ent, input logic [18:0] vppn);
      return (ent.vppn[18:9] == vppn[18:9]) && (ent.ps4m || (ent.vppn[8:0] == vppn[8:0]));
   endfunction

endpackage

// File: rtl/tlb_lookup.sv
// One TLB search port: associative match, lowest-index priority with multi-hit
// detection, odd/even page select, and a one-cycle registered result.
module tlb_lookup
   import tlb_pkg::*;
#(
   parameter int  TLBNUM = 16,
   localparam int IW     = $clog2(TLBNUM)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  tlb_entry_t [TLBNUM-1:0] ents_i,
   input  logic                    req_i,
   input  logic [18:0]             vppn_i,
   input  logic                    va_bit12_i,
   input  logic [9:0]              asid_i,
   output logic                    rvalid_o,
   output logic                    found_o,
   output logic                    multi_o,
   output logic [IW-1:0]           index_o,
   output logic [19:0]             ppn_o,
   output logic [5:0]              ps_o,
   output logic [1:0]              plv_o,
   output logic [1:0]              mat_o,
   output logic                    d_o,
   output logic                    v_o
);

   tlb_result_t   res_d, res_q;
   logic [IW-1:0] index_d, index_q;
   logic          rvalid_q;
   logic          hit;
   logic          odd;

   always_comb begin
      hit     = 1'b0;
      odd     = 1'b0;
      index_d = '0;
      res_d   = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         if (ents_i[i].e && va_eq(ents_i[i], vppn_i) &&
             (ents_i[i].g || (ents_i[i].asid == asid_i))) begin
            if (hit) res_d.multi = 1'b1;
            else     index_d     = IW'(i);
            hit = 1'b1;
         end
      end
      // 4MB pages pick the half from the VPPN itself, 4KB pages from VA bit 12.
      odd = ents_i[index_d].ps4m ? vppn_i[8] : va_bit12_i;
      if (hit) begin
         res_d.found = 1'b1;
         res_d.ps    = ents_i[index_d].ps4m ? PS_4M : PS_4K;
         res_d.page  = odd ? ents_i[index_d].p1 : ents_i[index_d].p0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rvalid_q <= 1'b0;
         res_q    <= '0;
         index_q  <= '0;
      end else begin
         rvalid_q <= req_i;
         if (req_i) begin
            res_q   <= res_d;
            index_q <= index_d;
         end
      end
   end

   assign rvalid_o = rvalid_q;
   assign found_o  = res_q.found;
   assign multi_o  = res_q.multi;
   assign index_o  = index_q;
   assign ppn_o    = res_q.page.ppn;
   assign ps_o     = res_q.ps;
   assign plv_o    = res_q.page.plv;
   assign mat_o    = res_q.page.mat;
   assign d_o      = res_q.page.d;
   assign v_o      = res_q.page.v;

endmodule

// File: rtl/tlb_pipe.sv
// Fully associative TLB with two registered search ports, a combinational read /
// registered write port, an INVTLB port and a free-running TLBFILL index.
module tlb_pipe
   import tlb_pkg::*;
#(
   parameter int  TLBNUM = 16,
   localparam int IW     = $clog2(TLBNUM)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          s0_req_i,
   input  logic [18:0]   s0_vppn_i,
   input  logic          s0_va_bit12_i,
   input  logic [9:0]    s0_asid_i,
   output logic          s0_rvalid_o,
   output logic          s0_found_o,
   output logic          s0_multi_o,
   output logic [IW-1:0] s0_index_o,
   output logic [19:0]   s0_ppn_o,
   output logic [5:0]    s0_ps_o,
   output logic [1:0]    s0_plv_o,
   output logic [1:0]    s0_mat_o,
   output logic          s0_d_o,
   output logic          s0_v_o,
   input  logic          s1_req_i,
   input  logic [18:0]   s1_vppn_i,
   input  logic          s1_va_bit12_i,
   input  logic [9:0]    s1_asid_i,
   output logic          s1_rvalid_o,
   output logic          s1_found_o,
   output logic          s1_multi_o,
   output logic [IW-1:0] s1_index_o,
   output logic [19:0]   s1_ppn_o,
   output logic [5:0]    s1_ps_o,
   output logic [1:0]    s1_plv_o,
   output logic [1:0]    s1_mat_o,
   output logic          s1_d_o,
   output logic          s1_v_o,
   input  logic          we_i,
   input  logic [IW-1:0] w_index_i,
   input  logic          w_e_i,
   input  logic [18:0]   w_vppn_i,
   input  logic [5:0]    w_ps_i,
   input  logic [9:0]    w_asid_i,
   input  logic          w_g_i,
   input  logic [19:0]   w_ppn0_i,
   input  logic [1:0]    w_plv0_i,
   input  logic [1:0]    w_mat0_i,
   input  logic          w_d0_i,
   input  logic          w_v0_i,
   input  logic [19:0]   w_ppn1_i,
   input  logic [1:0]    w_plv1_i,
   input  logic [1:0]    w_mat1_i,
   input  logic          w_d1_i,
   input  logic          w_v1_i,
   input  logic [IW-1:0] r_index_i,
   output logic          r_e_o,
   output logic [18:0]   r_vppn_o,
   output logic [5:0]    r_ps_o,
   output logic [9:0]    r_asid_o,
   output logic          r_g_o,
   output logic [19:0]   r_ppn0_o,
   output logic [1:0]    r_plv0_o,
   output logic [1:0]    r_mat0_o,
   output logic          r_d0_o,
   output logic          r_v0_o,
   output logic [19:0]   r_ppn1_o,
   output logic [1:0]    r_plv1_o,
   output logic [1:0]    r_mat1_o,
   output logic          r_d1_o,
   output logic          r_v1_o,
   input  logic          inv_valid_i,
   input  logic [4:0]    inv_op_i,
   input  logic [9:0]    inv_asid_i,
   input  logic [18:0]   inv_vppn_i,
   output logic          inv_ready_o,
   output logic          inv_err_o,
   output logic [IW-1:0] fill_index_o
);

   tlb_entry_t [TLBNUM-1:0] ent_q, ent_d;
   tlb_entry_t              wr_ent;
   logic [IW-1:0]           fill_q;
   logic                    inv_err_q;
   logic                    inv_go;
   logic                    kill;
   logic                    asid_eq;

   // A write in the same cycle stalls INVTLB; illegal ops are accepted but inert.
   assign inv_ready_o = inv_valid_i && !we_i && !reset_i;
   assign inv_go      = inv_ready_o && (inv_op_i <= INV_GASID_VA);

   always_comb begin
      wr_ent        = '0;
      wr_ent.e      = w_e_i;
      wr_ent.ps4m   = (w_ps_i == PS_4M);
      wr_ent.vppn   = w_vppn_i;
      wr_ent.asid   = w_asid_i;
      wr_ent.g      = w_g_i;
      wr_ent.p0.ppn = w_ppn0_i;
      wr_ent.p0.plv = w_plv0_i;
      wr_ent.p0.mat = w_mat0_i;
      wr_ent.p0.d   = w_d0_i;
      wr_ent.p0.v   = w_v0_i;
      wr_ent.p1.ppn = w_ppn1_i;
      wr_ent.p1.plv = w_plv1_i;
      wr_ent.p1.mat = w_mat1_i;
      wr_ent.p1.d   = w_d1_i;
      wr_ent.p1.v   = w_v1_i;
   end

   always_comb begin
      ent_d   = ent_q;
      kill    = 1'b0;
      asid_eq = 1'b0;
      if (we_i) begin
         ent_d[w_index_i] = wr_ent;
      end else if (inv_go) begin
         for (int i = 0; i < TLBNUM; i++) begin
            asid_eq = (ent_q[i].asid == inv_asid_i);
            case (inv_op_i)
               INV_ALL0, INV_ALL1: kill = 1'b1;
               INV_G1:             kill = ent_q[i].g;
               INV_G0:             kill = !ent_q[i].g;
               INV_ASID:           kill = !ent_q[i].g && asid_eq;
               INV_ASID_VA:        kill = !ent_q[i].g && asid_eq && va_eq(ent_q[i], inv_vppn_i);
               INV_GASID_VA:       kill = (ent_q[i].g || asid_eq) && va_eq(ent_q[i], inv_vppn_i);
               default:            kill = 1'b0;
            endcase
            if (kill) ent_d[i].e = 1'b0;
         end
      end
   end

   // Only the E bits need clearing on reset; the rest of an entry is unused until rewritten.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < TLBNUM; i++) ent_q[i].e <= 1'b0;
      end else begin
         ent_q <= ent_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fill_q    <= '0;
         inv_err_q <= 1'b0;
      end else begin
         fill_q    <= fill_q + IW'(1);
         inv_err_q <= inv_ready_o && (inv_op_i > INV_GASID_VA);
      end
   end

   assign fill_index_o = fill_q;
   assign inv_err_o    = inv_err_q;

   assign r_e_o    = ent_q[r_index_i].e;
   assign r_vppn_o = ent_q[r_index_i].vppn;
   assign r_ps_o   = ent_q[r_index_i].ps4m ? PS_4M : PS_4K;
   assign r_asid_o = ent_q[r_index_i].asid;
   assign r_g_o    = ent_q[r_index_i].g;
   assign r_ppn0_o = ent_q[r_index_i].p0.ppn;
   assign r_plv0_o = ent_q[r_index_i].p0.plv;
   assign r_mat0_o = ent_q[r_index_i].p0.mat;
   assign r_d0_o   = ent_q[r_index_i].p0.d;
   assign r_v0_o   = ent_q[r_index_i].p0.v;
   assign r_ppn1_o = ent_q[r_index_i].p1.ppn;
   assign r_plv1_o = ent_q[r_index_i].p1.plv;
   assign r_mat1_o = ent_q[r_index_i].p1.mat;
   assign r_d1_o   = ent_q[r_index_i].p1.d;
   assign r_v1_o   = ent_q[r_index_i].p1.v;

   tlb_lookup #(.TLBNUM(TLBNUM)) u_lookup0 (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .ents_i     (ent_q),
      .req_i      (s0_req_i),
      .vppn_i     (s0_vppn_i),
      .va_bit12_i (s0_va_bit12_i),
      .asid_i     (s0_asid_i),
      .rvalid_o   (s0_rvalid_o),
      .found_o    (s0_found_o),
      .multi_o    (s0_multi_o),
      .index_o    (s0_index_o),
      .ppn_o      (s0_ppn_o),
      .ps_o       (s0_ps_o),
      .plv_o      (s0_plv_o),
      .mat_o      (s0_mat_o),
      .d_o        (s0_d_o),
      .v_o        (s0_v_o)
   );

   tlb_lookup #(.TLBNUM(TLBNUM)) u_lookup1 (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .ents_i     (ent_q),
      .req_i      (s1_req_i),
      .vppn_i     (s1_vppn_i),
      .va_bit12_i (s1_va_bit12_i),
      .asid_i     (s1_asid_i),
      .rvalid_o   (s1_rvalid_o),
      .found_o    (s1_found_o),
      .multi_o    (s1_multi_o),
      .index_o    (s1_index_o),
      .ppn_o      (s1_ppn_o),
      .ps_o       (s1_ps_o),
      .plv_o      (s1_plv_o),
      .mat_o      (s1_mat_o),
      .d_o        (s1_d_o),
      .v_o        (s1_v_o)
   );

endmodule

// File: tb/tb_tlb_pipe.sv
// Bench for tlb_pipe: directed vector table and corner sequences plus random
// traffic, all checked against an array-based model of the TLB.
module tb_tlb_pipe;

   localparam int TLBNUM = 16;
   localparam int IW     = $clog2(TLBNUM);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          s0_req = 1'b0, s1_req = 1'b0;
   logic [18:0]   s0_vppn = '0, s1_vppn = '0;
   logic          s0_b12 = 1'b0, s1_b12 = 1'b0;
   logic [9:0]    s0_asid = '0, s1_asid = '0;
   logic          s0_rvalid, s0_found, s0_multi, s0_d, s0_v;
   logic          s1_rvalid, s1_found, s1_multi, s1_d, s1_v;
   logic [IW-1:0] s0_index, s1_index;
   logic [19:0]   s0_ppn, s1_ppn;
   logic [5:0]    s0_ps, s1_ps;
   logic [1:0]    s0_plv, s0_mat, s1_plv, s1_mat;
   logic          we = 1'b0;
   logic [IW-1:0] w_index = '0;
   logic          w_e = 1'b0, w_g = 1'b0;
   logic [18:0]   w_vppn = '0;
   logic [5:0]    w_ps = 6'd12;
   logic [9:0]    w_asid = '0;
   logic [19:0]   w_ppn0 = '0, w_ppn1 = '0;
   logic [1:0]    w_plv0 = '0, w_plv1 = '0, w_mat0 = '0, w_mat1 = '0;
   logic          w_d0 = 1'b0, w_v0 = 1'b0, w_d1 = 1'b0, w_v1 = 1'b0;
   logic [IW-1:0] r_index = '0;
   logic          r_e, r_g, r_d0, r_v0, r_d1, r_v1;
   logic [18:0]   r_vppn;
   logic [5:0]    r_ps;
   logic [9:0]    r_asid;
   logic [19:0]   r_ppn0, r_ppn1;
   logic [1:0]    r_plv0, r_mat0, r_plv1, r_mat1;
   logic          inv_valid = 1'b0;
   logic [4:0]    inv_op = '0;
   logic [9:0]    inv_asid = '0;
   logic [18:0]   inv_vppn = '0;
   logic          inv_ready, inv_err;
   logic [IW-1:0] fill_index;

   tlb_pipe #(.TLBNUM(TLBNUM)) dut (
      .clk_i(clk), .reset_i(reset),
      .s0_req_i(s0_req), .s0_vppn_i(s0_vppn), .s0_va_bit12_i(s0_b12), .s0_asid_i(s0_asid),
      .s0_rvalid_o(s0_rvalid), .s0_found_o(s0_found), .s0_multi_o(s0_multi), .s0_index_o(s0_index),
      .s0_ppn_o(s0_ppn), .s0_ps_o(s0_ps), .s0_plv_o(s0_plv), .s0_mat_o(s0_mat), .s0_d_o(s0_d), .s0_v_o(s0_v),
      .s1_req_i(s1_req), .s1_vppn_i(s1_vppn), .s1_va_bit12_i(s1_b12), .s1_asid_i(s1_asid),
      .s1_rvalid_o(s1_rvalid), .s1_found_o(s1_found), .s1_multi_o(s1_multi), .s1_index_o(s1_index),
      .s1_ppn_o(s1_ppn), .s1_ps_o(s1_ps), .s1_plv_o(s1_plv), .s1_mat_o(s1_mat), .s1_d_o(s1_d), .s1_v_o(s1_v),
      .we_i(we), .w_index_i(w_index), .w_e_i(w_e), .w_vppn_i(w_vppn), .w_ps_i(w_ps), .w_asid_i(w_asid), .w_g_i(w_g),
      .w_ppn0_i(w_ppn0), .w_plv0_i(w_plv0), .w_mat0_i(w_mat0), .w_d0_i(w_d0), .w_v0_i(w_v0),
      .w_ppn1_i(w_ppn1), .w_plv1_i(w_plv1), .w_mat1_i(w_mat1), .w_d1_i(w_d1), .w_v1_i(w_v1),
      .r_index_i(r_index), .r_e_o(r_e), .r_vppn_o(r_vppn), .r_ps_o(r_ps), .r_asid_o(r_asid), .r_g_o(r_g),
      .r_ppn0_o(r_ppn0), .r_plv0_o(r_plv0), .r_mat0_o(r_mat0), .r_d0_o(r_d0), .r_v0_o(r_v0),
      .r_ppn1_o(r_ppn1), .r_plv1_o(r_plv1), .r_mat1_o(r_mat1), .r_d1_o(r_d1), .r_v1_o(r_v1),
      .inv_valid_i(inv_valid), .inv_op_i(inv_op), .inv_asid_i(inv_asid), .inv_vppn_i(inv_vppn),
      .inv_ready_o(inv_ready), .inv_err_o(inv_err), .fill_index_o(fill_index)
   );

   typedef struct packed {
      logic          rvalid;
      logic          found;
      logic          multi;
      logic [IW-1:0] idx;
      logic [19:0]   ppn;
      logic [5:0]    ps;
      logic [1:0]    plv;
      logic [1:0]    mat;
      logic          d;
      logic          v;
   } res_t;

   typedef struct {
      logic [18:0]   vppn;
      logic          b12;
      logic [9:0]    asid;
      logic          found;
      logic          multi;
      logic [IW-1:0] idx;
      logic [19:0]   ppn;
      logic [5:0]    ps;
   } vec_t;

   // Reference TLB contents, one array per field.
   bit          m_e   [TLBNUM];
   bit          m_big [TLBNUM];
   bit          m_g   [TLBNUM];
   bit          m_wr  [TLBNUM];
   logic [18:0] m_vppn[TLBNUM];
   logic [9:0]  m_asid[TLBNUM];
   logic [19:0] m_ppn [TLBNUM][2];
   logic [1:0]  m_plv [TLBNUM][2];
   logic [1:0]  m_mat [TLBNUM][2];
   bit          m_d   [TLBNUM][2];
   bit          m_v   [TLBNUM][2];
   int          m_fill = 0;
   res_t        exp0 = '0, exp1 = '0;
   bit          exp_err = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [18:0] pool [5] = '{19'h12345, 19'h40000, 19'h401FF, 19'h0ABCD, 19'h12344};
   vec_t        vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit va_hit(int i, logic [18:0] vppn);
      if (m_big[i]) return (m_vppn[i] >> 9) == (vppn >> 9);
      return m_vppn[i] == vppn;
   endfunction

   function automatic res_t model_search(logic [18:0] vppn, logic b12, logic [9:0] asid);
      res_t r;
      int   n;
      int   k;
      int   h;
      r = '0;
      n = 0;
      k = 0;
      r.rvalid = 1'b1;
      for (int i = 0; i < TLBNUM; i++)
         if (m_e[i] && va_hit(i, vppn) && (m_g[i] || m_asid[i] == asid)) begin
            if (n == 0) k = i;
            n++;
         end
      if (n > 0) begin
         h       = m_big[k] ? int'(vppn[8]) : int'(b12);
         r.found = 1'b1;
         r.multi = (n > 1);
         r.idx   = IW'(k);
         r.ppn   = m_ppn[k][h];
         r.ps    = m_big[k] ? 6'd21 : 6'd12;
         r.plv   = m_plv[k][h];
         r.mat   = m_mat[k][h];
         r.d     = m_d[k][h];
         r.v     = m_v[k][h];
      end
      return r;
   endfunction

   task automatic model_write();
      int i;
      i = int'(w_index);
      m_e[i] = w_e;       m_big[i] = (w_ps == 6'd21);
      m_vppn[i] = w_vppn; m_asid[i] = w_asid; m_g[i] = w_g;
      m_ppn[i][0] = w_ppn0; m_plv[i][0] = w_plv0; m_mat[i][0] = w_mat0; m_d[i][0] = w_d0; m_v[i][0] = w_v0;
      m_ppn[i][1] = w_ppn1; m_plv[i][1] = w_plv1; m_mat[i][1] = w_mat1; m_d[i][1] = w_d1; m_v[i][1] = w_v1;
      m_wr[i] = 1'b1;
   endtask

   task automatic model_inv();
      for (int i = 0; i < TLBNUM; i++) begin
         bit ae;
         bit va;
         bit k;
         ae = (m_asid[i] == inv_asid);
         va = va_hit(i, inv_vppn);
         case (int'(inv_op))
            0, 1:    k = 1'b1;
            2:       k = m_g[i];
            3:       k = !m_g[i];
            4:       k = !m_g[i] && ae;
            5:       k = !m_g[i] && ae && va;
            6:       k = (m_g[i] || ae) && va;
            default: k = 1'b0;
         endcase
         if (k) m_e[i] = 1'b0;
      end
   endtask

   function automatic res_t dut_s0();
      return {s0_rvalid, s0_found, s0_multi, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v};
   endfunction

   function automatic res_t dut_s1();
      return {s1_rvalid, s1_found, s1_multi, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v};
   endfunction

   // One clock with the inputs already driven: check combinational outputs,
   // clock, advance the model, then check registered outputs.
   task automatic do_cycle();
      res_t n0;
      res_t n1;
      bit   acc;
      bit   n_err;
      int   ri;
      #1;
      ri = int'(r_index);
      check("r_e", 64'(r_e), 64'(m_e[ri]));
      if (m_wr[ri]) begin
         check("r_hdr", 64'({r_e, r_vppn, r_ps, r_asid, r_g}),
               64'({m_e[ri], m_vppn[ri], (m_big[ri] ? 6'd21 : 6'd12), m_asid[ri], m_g[ri]}));
         check("r_pages", 64'({r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1}),
               64'({m_ppn[ri][0], m_plv[ri][0], m_mat[ri][0], m_d[ri][0], m_v[ri][0],
                    m_ppn[ri][1], m_plv[ri][1], m_mat[ri][1], m_d[ri][1], m_v[ri][1]}));
      end
      acc = inv_valid && !we && !reset;
      check("inv_ready", 64'(inv_ready), 64'(acc));
      n0 = exp0;
      n0.rvalid = 1'b0;
      if (s0_req) n0 = model_search(s0_vppn, s0_b12, s0_asid);
      n1 = exp1;
      n1.rvalid = 1'b0;
      if (s1_req) n1 = model_search(s1_vppn, s1_b12, s1_asid);
      n_err = acc && (inv_op > 5'd6);
      if (reset) begin
         n0 = '0;
         n1 = '0;
         n_err = 1'b0;
      end
      @(posedge clk);
      exp0 = n0;
      exp1 = n1;
      exp_err = n_err;
      if (reset) begin
         m_e = '{default: 1'b0};
         m_fill = 0;
      end else begin
         m_fill = (m_fill + 1) % TLBNUM;
         if (we) model_write();
         else if (acc && inv_op <= 5'd6) model_inv();
      end
      @(negedge clk);
      check("s0_result", 64'(dut_s0()), 64'(exp0));
      check("s1_result", 64'(dut_s1()), 64'(exp1));
      check("inv_err", 64'(inv_err), 64'(exp_err));
      check("fill_index", 64'(fill_index), 64'(m_fill));
   endtask

   task automatic set_write(input int idx, input logic [18:0] vppn, input logic [5:0] ps,
                            input logic [9:0] asid, input logic g,
                            input logic [19:0] ppn0, input logic [19:0] ppn1);
      we = 1'b1; w_index = IW'(idx); r_index = IW'(idx);
      w_e = 1'b1; w_vppn = vppn; w_ps = ps; w_asid = asid; w_g = g;
      w_ppn0 = ppn0; w_plv0 = 2'd0; w_mat0 = 2'd1; w_d0 = 1'b1; w_v0 = 1'b1;
      w_ppn1 = ppn1; w_plv1 = 2'd3; w_mat1 = 2'd2; w_d1 = 1'b1; w_v1 = 1'b1;
   endtask

   task automatic write_ent(input int idx, input logic [18:0] vppn, input logic [5:0] ps,
                            input logic [9:0] asid, input logic g,
                            input logic [19:0] ppn0, input logic [19:0] ppn1);
      set_write(idx, vppn, ps, asid, g, ppn0, ppn1);
      do_cycle();
      we = 1'b0;
   endtask

   task automatic search(input logic [18:0] vppn, input logic b12, input logic [9:0] asid);
      s0_req = 1'b1; s0_vppn = vppn; s0_b12 = b12; s0_asid = asid;
      s1_req = 1'b1; s1_vppn = vppn; s1_b12 = b12; s1_asid = asid;
      do_cycle();
      s0_req = 1'b0;
      s1_req = 1'b0;
   endtask

   initial begin
      vecs[0] = '{19'h12345, 1'b1, 10'd5, 1'b1, 1'b0, IW'(3), 20'hBBBBB, 6'd12};
      vecs[1] = '{19'h12345, 1'b0, 10'd5, 1'b1, 1'b0, IW'(3), 20'hAAAAA, 6'd12};
      vecs[2] = '{19'h12345, 1'b1, 10'd6, 1'b0, 1'b0, IW'(0), 20'h00000, 6'd0};
      vecs[3] = '{19'h401FF, 1'b0, 10'd9, 1'b1, 1'b0, IW'(7), 20'h22222, 6'd21};
      vecs[4] = '{19'h40000, 1'b1, 10'd9, 1'b1, 1'b0, IW'(7), 20'h11111, 6'd21};
      vecs[5] = '{19'h0ABCD, 1'b0, 10'd1, 1'b1, 1'b1, IW'(2), 20'h33333, 6'd12};
      vecs[6] = '{19'h0ABCD, 1'b0, 10'd2, 1'b0, 1'b0, IW'(0), 20'h00000, 6'd0};
      vecs[7] = '{19'h40200, 1'b0, 10'd9, 1'b0, 1'b0, IW'(0), 20'h00000, 6'd0};

      @(posedge clk);
      @(negedge clk);
      do_cycle();
      check("reset_state", 64'({s0_rvalid, s0_found, s1_rvalid, inv_err, fill_index}), 64'(0));
      reset = 1'b0;

      for (int k = 1; k <= TLBNUM; k++) begin
         do_cycle();
         check("fill_seq", 64'(fill_index), 64'(k % TLBNUM));
      end

      search(19'h00001, 1'b0, 10'd0);
      check("first_search", 64'({s0_rvalid, s0_found, s0_index}), 64'({1'b1, 1'b0, IW'(0)}));

      write_ent(3, 19'h12345, 6'd12, 10'd5, 1'b0, 20'hAAAAA, 20'hBBBBB);
      write_ent(7, 19'h40000, 6'd21, 10'd0, 1'b1, 20'h11111, 20'h22222);
      write_ent(2, 19'h0ABCD, 6'd12, 10'd1, 1'b0, 20'h33333, 20'h44444);
      write_ent(9, 19'h0ABCD, 6'd12, 10'd1, 1'b0, 20'h55555, 20'h66666);

      for (int i = 0; i < 8; i++) begin
         search(vecs[i].vppn, vecs[i].b12, vecs[i].asid);
         check($sformatf("vec%0d_s0", i), 64'({s0_found, s0_multi, s0_index, s0_ppn, s0_ps}),
               64'({vecs[i].found, vecs[i].multi, vecs[i].idx, vecs[i].ppn, vecs[i].ps}));
         check($sformatf("vec%0d_s1", i), 64'({s1_found, s1_multi, s1_index, s1_ppn, s1_ps}),
               64'({vecs[i].found, vecs[i].multi, vecs[i].idx, vecs[i].ppn, vecs[i].ps}));
      end

      // INVTLB held off by a concurrent write, then accepted.
      inv_valid = 1'b1; inv_op = 5'd4; inv_asid = 10'd5; inv_vppn = 19'h0;
      set_write(12, 19'h55555, 6'd12, 10'd7, 1'b0, 20'h12121, 20'h34343);
      #1;
      check("inv_blocked", 64'(inv_ready), 64'(0));
      do_cycle();
      we = 1'b0;
      #1;
      check("inv_accept", 64'(inv_ready), 64'(1));
      do_cycle();
      inv_valid = 1'b0;
      search(19'h12345, 1'b1, 10'd5);
      check("inv_cleared", 64'(s0_found), 64'(0));
      search(19'h401FF, 1'b0, 10'd9);
      check("inv_kept_g", 64'({s0_found, s0_index}), 64'({1'b1, IW'(7)}));

      inv_valid = 1'b1; inv_op = 5'd9;
      do_cycle();
      inv_valid = 1'b0;
      check("inv_err_pulse", 64'(inv_err), 64'(1));
      do_cycle();
      check("inv_err_drop", 64'(inv_err), 64'(0));
      search(19'h0ABCD, 1'b0, 10'd1);
      check("illegal_inert", 64'({s0_found, s0_multi, s0_index}), 64'({1'b1, 1'b1, IW'(2)}));

      // Search in the same cycle as a write to the hit entry sees old data.
      s0_req = 1'b1; s0_vppn = 19'h401FF; s0_b12 = 1'b0; s0_asid = 10'd9;
      set_write(7, 19'h40000, 6'd21, 10'd0, 1'b1, 20'h11111, 20'h77777);
      do_cycle();
      we = 1'b0;
      s0_req = 1'b0;
      check("same_cycle_old", 64'(s0_ppn), 64'(20'h22222));
      search(19'h401FF, 1'b0, 10'd9);
      check("next_cycle_new", 64'(s0_ppn), 64'(20'h77777));

      // Reset arriving with a search pending drops the result.
      reset = 1'b1;
      s0_req = 1'b1; s0_vppn = 19'h401FF; s0_asid = 10'd9;
      do_cycle();
      s0_req = 1'b0;
      reset = 1'b0;
      check("reset_drop", 64'({s0_rvalid, s0_found}), 64'(0));
      search(19'h401FF, 1'b0, 10'd9);
      check("reset_cleared", 64'({s0_rvalid, s0_found}), 64'({1'b1, 1'b0}));

      for (int t = 0; t < 500; t++) begin
         reset     = ($urandom_range(0, 99) == 0);
         we        = ($urandom_range(0, 2) == 0);
         w_index   = IW'($urandom_range(0, TLBNUM - 1));
         w_e       = ($urandom_range(0, 7) != 0);
         w_vppn    = pool[$urandom_range(0, 4)];
         w_ps      = ($urandom_range(0, 1) == 1) ? 6'd21 : 6'd12;
         w_asid    = 10'($urandom_range(0, 3));
         w_g       = ($urandom_range(0, 3) == 0);
         w_ppn0    = 20'($urandom);
         w_ppn1    = 20'($urandom);
         w_plv0    = 2'($urandom);
         w_plv1    = 2'($urandom);
         w_mat0    = 2'($urandom);
         w_mat1    = 2'($urandom);
         w_d0      = 1'($urandom);
         w_d1      = 1'($urandom);
         w_v0      = 1'($urandom);
         w_v1      = 1'($urandom);
         inv_valid = ($urandom_range(0, 9) == 0);
         inv_op    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(7, 31)) : 5'($urandom_range(0, 6));
         inv_asid  = 10'($urandom_range(0, 3));
         inv_vppn  = pool[$urandom_range(0, 4)];
         s0_req    = ($urandom_range(0, 3) != 0);
         s0_vppn   = pool[$urandom_range(0, 4)];
         s0_b12    = 1'($urandom);
         s0_asid   = 10'($urandom_range(0, 3));
         s1_req    = ($urandom_range(0, 3) != 0);
         s1_vppn   = pool[$urandom_range(0, 4)];
         s1_b12    = 1'($urandom);
         s1_asid   = 10'($urandom_range(0, 3));
         r_index   = IW'($urandom_range(0, TLBNUM - 1));
         do_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
